// File: rtl/weight_buf_pkg.sv
// Weight-buffer layout shared by the distributer and the fetcher.
// It also holds the fetcher FSM state type.
package weight_buf_pkg;

    localparam int unsigned WBUF_DEPTH  = 2720;
    localparam int unsigned WBUF_DATA_W = 72;

    localparam int unsigned CONV1_BASE = 0;
    localparam int unsigned CONV1_LEN  = 8;
    localparam int unsigned CONV2_BASE = 32;
    localparam int unsigned CONV2_LEN  = 128;
    localparam int unsigned FC_BASE    = 160;
    localparam int unsigned FC_LEN     = 2560;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } wf_state_t;

endpackage

// File: rtl/wfetch_fifo.sv
// Small synchronous FIFO for the fetcher output: data+last per entry,
// register-array storage, occupancy count exported for credit accounting.
module wfetch_fifo #(
    parameter int unsigned WIDTH = 73,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok = pop && (count != '0);
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end

    overflow_check: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop_ok && (count == CW'(DEPTH))));

endmodule

// File: rtl/weight_fetcher.sv
// Streams a contiguous run of weight-buffer words to the PE array.
// Reads are credit-limited against the output FIFO so backpressure never drops data.
module weight_fetcher
    import weight_buf_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned DATA_W     = WBUF_DATA_W,
    parameter int unsigned DEPTH      = WBUF_DEPTH,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wload_done,
    output logic              weights_ready,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              cmd_err,
    output logic              wbuf_enb,
    output logic [ADDR_W-1:0] wbuf_addrb,
    input  logic [DATA_W-1:0] wbuf_doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    wf_state_t         state;
    wf_state_t         state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] issued;
    logic              err_q;
    logic              zero_done_q;
    logic [RD_LAT-1:0] vld;
    logic [RD_LAT-1:0] tag;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_dout;
    logic              accept;
    logic              range_bad;
    logic              issue;
    logic              drain_done;
    logic              credit_ok;

    assign accept    = cmd_valid && cmd_ready;
    assign range_bad = ({1'b0, cmd_base} + {1'b0, cmd_len}) > (ADDR_W + 1)'(DEPTH);
    assign inflight  = CW'($countones(vld));
    assign credit_ok = ({1'b0, fifo_count} + {1'b0, inflight}) < (CW + 1)'(FIFO_DEPTH);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept && !range_bad && (cmd_len != '0)) state_next = STREAM;
            STREAM:  if (issued == len_q) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (state == IDLE) && weights_ready;
        busy       = (state != IDLE);
        issue      = (state == STREAM) && credit_ok && (issued < len_q);
        drain_done = (state == DRAIN) && (fifo_count == '0) && (vld == '0);
        wbuf_enb   = issue;
        wbuf_addrb = issue ? base_q + issued : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            weights_ready <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            issued        <= '0;
            err_q         <= 1'b0;
            zero_done_q   <= 1'b0;
        end else begin
            if (wload_done) weights_ready <= 1'b1;
            err_q       <= accept && range_bad;
            zero_done_q <= accept && !range_bad && (cmd_len == '0);
            if (accept) begin
                base_q <= cmd_base;
                len_q  <= cmd_len;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + ADDR_W'(1);
            end
        end
    end

    // The last flag rides alongside each read so the output never recomputes it.
    generate
        if (RD_LAT > 1) begin : g_lat_multi
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    vld <= '0;
                    tag <= '0;
                end else begin
                    vld <= {vld[RD_LAT-2:0], issue};
                    tag <= {tag[RD_LAT-2:0], issue && (issued == len_q - ADDR_W'(1))};
                end
            end
        end else begin : g_lat_single
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    vld <= '0;
                    tag <= '0;
                end else begin
                    vld <= issue;
                    tag <= issue && (issued == len_q - ADDR_W'(1));
                end
            end
        end
    endgenerate

    wfetch_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (vld[RD_LAT-1]),
        .din    ({tag[RD_LAT-1], wbuf_doutb}),
        .pop    (m_valid && m_ready),
        .dout   (fifo_dout),
        .count  (fifo_count)
    );

    assign m_valid = (fifo_count != '0);
    assign m_data  = fifo_dout[DATA_W-1:0];
    assign m_last  = m_valid && fifo_dout[DATA_W];
    assign cmd_err = err_q;
    assign done    = zero_done_q || drain_done;

endmodule

// File: tb/tb_weight_fetcher.sv
// Randomized bench for weight_fetcher against a queue-based model of the
// expected word stream, command outcomes and handshake flags.
module tb_weight_fetcher;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 72;
    localparam int unsigned ND = 2720;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          wload_done = 1'b0;
    logic          weights_ready;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          cmd_err;
    logic          wbuf_enb;
    logic [AW-1:0] wbuf_addrb;
    logic [DW-1:0] wbuf_doutb = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    weight_fetcher #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (ND),
        .RD_LAT     (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wload_done    (wload_done),
        .weights_ready (weights_ready),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .cmd_err       (cmd_err),
        .wbuf_enb      (wbuf_enb),
        .wbuf_addrb    (wbuf_addrb),
        .wbuf_doutb    (wbuf_doutb),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] wmem [ND];

    // model state
    logic [DW:0] exp_q [$];
    bit          exp_active, err_due, done_due, last_pop, wr_exp;
    bit          prev_stall, first_pend;
    logic [DW:0] prev_word;
    int          issue_left, next_addr, acc_cyc;
    int          cyc = 0;
    int          beats = 0, done_cnt = 0, err_cnt = 0, enb_cnt = 0;
    int          fifo_max = 0;
    int          rmode = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout expected=event", nm);
    endtask

    always @(posedge clk) begin
        if (wbuf_enb && (wbuf_addrb < AW'(ND))) wbuf_doutb <= wmem[wbuf_addrb];
    end

    always @(posedge clk) begin
        #1;
        m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // compare process: check first, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        logic [DW:0] cur;
        logic [DW:0] front;
        cyc++;
        if (!resetn) begin
            exp_q.delete();
            exp_active = 0; err_due = 0; done_due = 0; last_pop = 0; wr_exp = 0;
            prev_stall = 0; first_pend = 0; issue_left = 0;
        end else begin
            cur = {m_last, m_data};
            chk("weights_ready", weights_ready, wr_exp);
            chk("cmd_ready", cmd_ready, !exp_active && wr_exp);
            chk("busy", busy, exp_active);
            chk("cmd_err", cmd_err, err_due);
            chk("done", done, done_due || last_pop);
            if (cmd_err) err_cnt++;
            if (done) done_cnt++;
            if (wbuf_enb) begin
                enb_cnt++;
                chk("enb_allowed", exp_active && (issue_left > 0), 1'b1);
                if (exp_active && (issue_left > 0)) begin
                    chk("rd_addr", wbuf_addrb, next_addr);
                    next_addr++;
                    issue_left--;
                end
            end
            if (prev_stall) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_hold", cur, prev_word);
            end
            if (m_valid && first_pend) begin
                chk("first_latency", cyc - acc_cyc, 3);
                first_pend = 0;
            end
            if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);

            if (last_pop) exp_active = 0;
            err_due = 0; done_due = 0; last_pop = 0;

            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL beat_unexpected actual=%0h expected=none", cur);
                end else begin
                    front = exp_q.pop_front();
                    chk("beat_word", cur, front);
                    if (exp_q.size() == 0) last_pop = 1;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_word  = cur;

            if (wload_done) wr_exp = 1;
            if (cmd_valid && cmd_ready) begin
                if (int'(cmd_base) + int'(cmd_len) > ND) err_due = 1;
                else if (cmd_len == 0) done_due = 1;
                else begin
                    exp_active = 1;
                    issue_left = int'(cmd_len);
                    next_addr  = int'(cmd_base);
                    first_pend = 1;
                    acc_cyc    = cyc;
                    for (int i = 0; i < int'(cmd_len); i++)
                        exp_q.push_back({(i == int'(cmd_len) - 1), wmem[int'(cmd_base) + i]});
                end
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cmd_ready) fail_now("accept_wait");
        else begin
            @(posedge clk); #1;
        end
        cmd_valid = 0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((exp_active || err_due || done_due || last_pop) && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_active || err_due || done_due || last_pop) fail_now("idle_wait");
    endtask

    task automatic issue_cmd(input int base, input int len);
        cmd_base  = AW'(base);
        cmd_len   = AW'(len);
        cmd_valid = 1;
        wait_accept();
    endtask

    task automatic pulse_wload();
        wload_done = 1;
        @(posedge clk); #1;
        wload_done = 0;
    endtask

    task automatic check_zero_outputs(input string nm);
        chk(nm, {weights_ready, cmd_ready, cmd_err, wbuf_enb, wbuf_addrb,
                 m_valid, m_data, m_last, busy, done}, '0);
    endtask

    initial begin
        int b0, d0, e0, n0, n;
        logic [95:0] r;
        void'($urandom(1));
        for (int i = 0; i < int'(ND); i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            wmem[i] = r[DW-1:0];
        end

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset_outputs");
        resetn = 1;
        @(posedge clk); #1;

        // command held off until weights are loaded
        e0 = enb_cnt; b0 = beats; d0 = done_cnt;
        cmd_base = 0; cmd_len = 8; cmd_valid = 1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("held_off_ready", cmd_ready, 1'b0);
        end
        chk("held_off_no_enb", enb_cnt - e0, 0);
        pulse_wload();
        chk("weights_ready_set", weights_ready, 1'b1);
        wait_accept();
        wait_idle(100);
        chk("conv1_beats", beats - b0, 8);
        chk("conv1_done", done_cnt - d0, 1);

        // full-rate conv2 with a repeated wload_done pulse mid-stream
        b0 = beats; d0 = done_cnt;
        issue_cmd(32, 128);
        repeat (10) @(posedge clk);
        #1;
        pulse_wload();
        wait_idle(400);
        chk("conv2_beats", beats - b0, 128);
        chk("conv2_done", done_cnt - d0, 1);

        // fc under random backpressure
        rmode = 1;
        b0 = beats; d0 = done_cnt;
        issue_cmd(160, 2560);
        wait_idle(20000);
        rmode = 0;
        chk("fc_beats", beats - b0, 2560);
        chk("fc_done", done_cnt - d0, 1);
        chk("fifo_max_le4", fifo_max <= 4, 1'b1);

        // out of range, then exactly at the top of the buffer
        e0 = enb_cnt; n0 = err_cnt; d0 = done_cnt;
        issue_cmd(2700, 32);
        wait_idle(10);
        repeat (2) @(posedge clk);
        #1;
        chk("err_pulses", err_cnt - n0, 1);
        chk("err_no_enb", enb_cnt - e0, 0);
        chk("err_no_done", done_cnt - d0, 0);
        b0 = beats; d0 = done_cnt;
        issue_cmd(2688, 32);
        wait_idle(200);
        chk("top_beats", beats - b0, 32);
        chk("top_done", done_cnt - d0, 1);

        // zero-length command
        b0 = beats; d0 = done_cnt;
        issue_cmd(5, 0);
        wait_idle(10);
        chk("len0_done", done_cnt - d0, 1);
        chk("len0_beats", beats - b0, 0);
        chk("len0_ready_after", cmd_ready, 1'b1);

        // reset mid-stream
        b0 = beats;
        issue_cmd(32, 128);
        n = 0;
        while ((beats - b0) < 40 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if ((beats - b0) < 40) fail_now("beat40_wait");
        resetn = 0;
        #1;
        check_zero_outputs("midstream_reset_outputs");
        repeat (2) @(posedge clk);
        #1;
        resetn = 1;
        e0 = enb_cnt; b0 = beats; d0 = done_cnt;
        cmd_base = 0; cmd_len = 8; cmd_valid = 1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("post_reset_blocked", cmd_ready, 1'b0);
        end
        chk("post_reset_no_enb", enb_cnt - e0, 0);
        chk("post_reset_no_done", done_cnt - d0, 0);
        pulse_wload();
        wait_accept();
        wait_idle(100);
        chk("post_reset_beats", beats - b0, 8);
        chk("post_reset_done", done_cnt - d0, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
